// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the multicycle execute stage:
//   - opcode encodings (OP_ADD .. OP_DIVU; 3'b11x are reserved)
//   - FSM state enum for the execute unit
//   - mode select for the shared shift/add/subtract core
//   - DIVZ_QUOT: quotient returned for a divide by zero (all ones); sliced
//     down to the operand width by the user (operand widths up to 64 bits).
// -----------------------------------------------------------------------------
package exec_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    CORE_MUL = 1'b0,
    CORE_DIV = 1'b1
  } core_mode_e;

  localparam logic [63:0] DIVZ_QUOT = '1;

endpackage

// File: rtl/multicycle_exec_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_exec_unit_if
// Handshake/data bundle between the phase controller (master) and the
// execute unit (slave).
//   IDecode, Exec          phase strobes from the controller
//   op, opa, opb           instruction opcode and operands
//   Instdone               execute unit tells the controller to leave Exec
//   result_lo, result_hi   registered results
//   busy                   operation latched and not yet finished
// -----------------------------------------------------------------------------
interface multicycle_exec_unit_if #(
  parameter int WIDTH = 8
);
  logic             IDecode;
  logic             Exec;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             Instdone;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             busy;

  modport master (
    output IDecode, Exec, op, opa, opb,
    input  Instdone, result_lo, result_hi, busy
  );

  modport slave (
    input  IDecode, Exec, op, opa, opb,
    output Instdone, result_lo, result_hi, busy
  );
endinterface

// File: rtl/shift_add_sub_core.sv
// -----------------------------------------------------------------------------
// shift_add_sub_core
// One iteration of an unsigned multiply or divide, purely combinational.
//   acc_hi, acc_lo   current accumulator pair
//   operand          multiplicand (MUL) or divisor (DIVU)
//   mode             CORE_MUL / CORE_DIV
//   acc_hi_nxt/lo    accumulator pair after this step
// MUL (LSB first): acc_lo starts as the multiplier, acc_hi as zero. Each step
//   conditionally adds the multiplicand to acc_hi and shifts {carry,hi,lo}
//   right by one; after WIDTH steps {hi,lo} is the full product.
// DIVU (restoring, MSB first): acc_lo starts as the dividend, acc_hi as zero.
//   Each step shifts the next dividend bit into the partial remainder, tries
//   the subtraction, and shifts the quotient bit into acc_lo.
// -----------------------------------------------------------------------------
module shift_add_sub_core
  import exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  input  core_mode_e       mode,
  output logic [WIDTH-1:0] acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};

    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;

    if (mode == CORE_MUL) begin
      {acc_hi_nxt, acc_lo_nxt} = {sum, acc_lo[WIDTH-1:1]};
    end else begin
      // The partial remainder stays below the divisor, so shifted < 2*divisor
      // and diff's top bit is set exactly when the trial subtraction borrows.
      if (!diff[WIDTH]) begin
        acc_hi_nxt = diff[WIDTH-1:0];
        acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_nxt = shifted[WIDTH-1:0];
        acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/multicycle_exec_unit.sv
// -----------------------------------------------------------------------------
// multicycle_exec_unit
// Variable-latency execute stage for a one-hot phase controller.
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus (slave)  IDecode/Exec strobes, op/opa/opb in; Instdone, result_lo,
//                result_hi, busy out
// Operands are latched on IDecode. ALU ops (and divide by zero) finish in the
// first Exec cycle; MUL/DIVU iterate one step per Exec cycle for WIDTH cycles,
// stalling whenever Exec is low. Instdone is raised combinationally in the
// final Exec cycle; results are registered and valid from the next cycle.
// Exec seen while idle or done answers Instdone at once so the controller
// can never hang waiting on this unit.
// -----------------------------------------------------------------------------
module multicycle_exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_exec_unit_if.slave bus
);

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             instdone;

  logic [WIDTH-1:0] alu_lo, alu_hi;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [WIDTH-1:0] core_operand;
  core_mode_e       core_mode;

  // The iterative core adds the multiplicand for MUL and subtracts the
  // divisor for DIVU.
  assign core_mode    = (op_q == OP_DIVU) ? CORE_DIV : CORE_MUL;
  assign core_operand = (op_q == OP_DIVU) ? opb_q : opa_q;

  shift_add_sub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .operand    (core_operand),
    .mode       (core_mode),
    .acc_hi_nxt (core_hi),
    .acc_lo_nxt (core_lo)
  );

  // Single-cycle results. DIVU only reaches READY when the divisor is zero.
  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    case (op_q)
      OP_ADD:  alu_lo = opa_q + opb_q;
      OP_SUB:  alu_lo = opa_q - opb_q;
      OP_AND:  alu_lo = opa_q & opb_q;
      OP_OR:   alu_lo = opa_q | opb_q;
      OP_DIVU: begin
        alu_lo = DIVZ_QUOT[WIDTH-1:0];
        alu_hi = opa_q;
      end
      default: begin
        alu_lo = '0;
        alu_hi = '0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    instdone = 1'b0;

    if (bus.IDecode) begin
      // Restart from any state; a simultaneous Exec is ignored.
      op_d     = bus.op;
      opa_d    = bus.opa;
      opb_d    = bus.opb;
      cnt_d    = '0;
      acc_hi_d = '0;
      // The low accumulator is seeded with the operand that gets shifted out.
      acc_lo_d = (bus.op == OP_MUL) ? bus.opb : bus.opa;
      if (bus.op == OP_MUL || (bus.op == OP_DIVU && bus.opb != '0)) begin
        state_d = ITER;
      end else begin
        state_d = READY;
      end
    end else if (bus.Exec) begin
      case (state_q)
        READY: begin
          instdone = 1'b1;
          res_lo_d = alu_lo;
          res_hi_d = alu_hi;
          state_d  = DONE;
        end
        ITER: begin
          acc_hi_d = core_hi;
          acc_lo_d = core_lo;
          if (cnt_q == LAST_STEP) begin
            instdone = 1'b1;
            res_lo_d = core_lo;
            res_hi_d = core_hi;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          instdone = 1'b1;
        end
      endcase
    end

    // Reset overrides the handshake so nothing is reported while aborting.
    if (rst) begin
      instdone = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign bus.Instdone  = instdone;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.busy      = (state_q == READY) || (state_q == ITER);

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_exec_unit
// Drives the execute unit the way the phase controller would (IDecode, then
// Exec until Instdone), plus raw random phase traffic and resets. A reference
// model computes each result arithmetically at decode time and counts the Exec
// cycles the operation needs; a compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_exec_unit;
  import exec_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_exec_unit_if #(.WIDTH(W)) bus ();

  multicycle_exec_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy = 1'b0;
  int         m_need = 0;
  int         m_done = 0;
  logic [W-1:0] m_lo = '0, m_hi = '0;
  logic [W-1:0] p_lo = '0, p_hi = '0;

  function automatic void predict(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi);
    logic [2*W-1:0] prod;
    lo = '0;
    hi = '0;
    prod = (2*W)'(a) * (2*W)'(b);
    case (o)
      3'd0: lo = a + b;
      3'd1: lo = a - b;
      3'd2: lo = a & b;
      3'd3: lo = a | b;
      3'd4: {hi, lo} = prod;
      3'd5: begin
        if (b == '0) begin
          lo = '1;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: begin
        lo = '0;
        hi = '0;
      end
    endcase
  endfunction

  // Compare on the falling edge (inputs are stable), then advance the model
  // to what the next rising edge must produce.
  initial begin
    bit exp_done;
    forever begin
      @(negedge clk);
      exp_done = 1'b0;
      if (!rst && !bus.IDecode && bus.Exec)
        exp_done = m_busy ? (m_done + 1 == m_need) : 1'b1;
      chk("Instdone", 32'(bus.Instdone), 32'(exp_done));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("result_lo", 32'(bus.result_lo), 32'(m_lo));
      chk("result_hi", 32'(bus.result_hi), 32'(m_hi));

      if (rst) begin
        m_busy = 1'b0;
        m_lo   = '0;
        m_hi   = '0;
      end else if (bus.IDecode) begin
        predict(bus.op, bus.opa, bus.opb, p_lo, p_hi);
        m_need = (bus.op == OP_MUL || (bus.op == OP_DIVU && bus.opb != '0)) ? W : 1;
        m_done = 0;
        m_busy = 1'b1;
      end else if (bus.Exec && m_busy) begin
        m_done++;
        if (m_done == m_need) begin
          m_busy = 1'b0;
          m_lo   = p_lo;
          m_hi   = p_hi;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic idec, input logic ex, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.IDecode = idec;
    bus.Exec    = ex;
    bus.op      = o;
    bus.opa     = a;
    bus.opb     = b;
  endtask

  // Non-decode cycles carry random operand junk that must be ignored.
  task automatic drive_noise(input logic ex);
    drive(1'b0, ex, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
  endtask

  // One instruction as the controller runs it: IDecode, Exec until Instdone
  // (optionally dropping Exec for stall_len cycles after stall_at steps),
  // then return positioned in the following (Mem) cycle with inputs idle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall_at, input int stall_len, output int n_exec);
    int stalled;
    bit done;
    stalled = 0;
    done    = 1'b0;
    n_exec  = 0;
    drive(1'b1, 1'b0, o, a, b);
    step();
    for (int c = 0; c < 64 && !done; c++) begin
      if (n_exec == stall_at && stalled < stall_len) begin
        drive_noise(1'b0);
        stalled++;
      end else begin
        drive_noise(1'b1);
        n_exec++;
        #1;
        if (bus.Instdone === 1'b1) done = 1'b1;
      end
      step();
    end
    drive_noise(1'b0);
    #1;
    if (!done) n_exec = -1;
    $display("txn op=%0d a=%02h b=%02h exec_cycles=%0d lo=%02h hi=%02h",
             o, a, b, n_exec, bus.result_lo, bus.result_hi);
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_lo", 32'(bus.result_lo), 32'd0);
    chk("reset_hi", 32'(bus.result_hi), 32'd0);
    chk("reset_instdone", 32'(bus.Instdone), 32'd0);

    run_op(OP_ADD, 8'h7F, 8'h01, -1, 0, n);
    chk("add_latency", 32'(n), 32'd1);
    chk("add_lo", 32'(bus.result_lo), 32'h80);
    chk("add_hi", 32'(bus.result_hi), 32'h00);
    chk("add_model", 32'(m_lo), 32'h80);

    run_op(OP_SUB, 8'h00, 8'h01, -1, 0, n);
    chk("sub_wrap_lo", 32'(bus.result_lo), 32'hFF);

    run_op(OP_OR, 8'hF0, 8'h0F, -1, 0, n);
    chk("or_lo", 32'(bus.result_lo), 32'hFF);

    run_op(OP_MUL, 8'hFF, 8'hFF, -1, 0, n);
    chk("mul_latency", 32'(n), 32'd8);
    chk("mul_product", 32'({bus.result_hi, bus.result_lo}), 32'hFE01);
    chk("mul_busy_after", 32'(bus.busy), 32'd0);
    chk("mul_model", 32'({m_hi, m_lo}), 32'hFE01);

    run_op(OP_DIVU, 8'd200, 8'd7, 3, 2, n);
    chk("divu_active_exec", 32'(n), 32'd8);
    chk("divu_quot", 32'(bus.result_lo), 32'd28);
    chk("divu_rem", 32'(bus.result_hi), 32'd4);
    chk("divu_model", 32'({m_hi, m_lo}), 32'({8'd4, 8'd28}));

    run_op(OP_DIVU, 8'h2A, 8'h00, -1, 0, n);
    chk("divz_latency", 32'(n), 32'd1);
    chk("divz_lo", 32'(bus.result_lo), 32'hFF);
    chk("divz_hi", 32'(bus.result_hi), 32'h2A);

    // Reset at the fourth MUL step.
    drive(1'b1, 1'b0, OP_MUL, 8'h12, 8'h34);
    step();
    repeat (3) begin
      drive_noise(1'b1);
      step();
    end
    rst = 1'b1;
    drive_noise(1'b1);
    step();
    rst = 1'b0;
    drive_noise(1'b0);
    #1;
    chk("rst_instdone", 32'(bus.Instdone), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_results", 32'({bus.result_hi, bus.result_lo}), 32'd0);
    run_op(OP_ADD, 8'd3, 8'd4, -1, 0, n);
    chk("post_rst_add", 32'(bus.result_lo), 32'd7);

    // Controller-style MUL followed by ADD.
    run_op(OP_MUL, 8'h0F, 8'h11, -1, 0, n);
    chk("ctl_mul_exec", 32'(n), 32'd8);
    chk("ctl_mul_res", 32'({bus.result_hi, bus.result_lo}), 32'h00FF);
    run_op(OP_ADD, 8'h10, 8'h20, -1, 0, n);
    chk("ctl_add_exec", 32'(n), 32'd1);
    chk("ctl_add_res", 32'({bus.result_hi, bus.result_lo}), 32'h0030);

    // Randomized instructions with random stalls, checked by the model.
    repeat (100) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_op(o, a, b, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), n);
      chk("rand_completed", 32'(n > 0), 32'd1);
    end

    // Raw random phase traffic: restarts, Exec in idle/done, resets.
    repeat (2000) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0)
        drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom),
              ($urandom_range(0, 4) == 0) ? '0 : W'($urandom));
      else
        drive_noise(1'($urandom_range(0, 3) != 0));
      step();
    end
    rst = 1'b0;
    drive_noise(1'b0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
